weight_stream_loader: RTL
=========================

# weight_stream_loader

Upstream feeder for the kernel weight controller. It accepts 8-bit weights on a valid/ready byte stream and packs every 9 bytes into one 72-bit 3x3 kernel word. Kernel words are distributed round-robin over the 4 weight-memory banks (one bank per MAC lane), with a write port matching a 1024x72 single-port RAM per bank. The weight controller then reads bank addresses 0..N-1 in parallel. A lock input blocks writes while the controller is reading.

## Interface
- DATA_W, 8, weight byte width
- KERNEL_WIDTH, 72, packed kernel word (9 x DATA_W)
- NUM_BANKS, 4, weight banks / MAC lanes
- ADDR_WIDTH, 10, bank address width
- MAX_KERNELS, 64, kernels per load (NUM_BANKS x 16)

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- i_start  in  1  pulse; begins a load, ignored unless IDLE
- i_lock  in  1  weight controller reading; stalls the stream
- i_s_valid  in  1  stream byte valid
- i_s_data  in  DATA_W  stream weight byte
- i_s_last  in  1  marks final byte of the load
- o_s_ready  out  1  stream ready
- o_wr_en  out  NUM_BANKS  one-hot bank write strobe
- o_wr_addr  out  ADDR_WIDTH  bank write address
- o_wr_data  out  KERNEL_WIDTH  packed kernel
- o_busy  out  1  high in LOAD or DONE
- o_done  out  1  one-cycle pulse, load completed cleanly
- o_err  out  1  sticky error flag
- o_kernel_cnt  out  7  kernels written in current/last load

## Operation
- FSM: IDLE, LOAD, DONE, ERR.
  - IDLE: i_start -> LOAD; clears byte_idx, kernel_cnt, o_err.
  - LOAD: o_s_ready = !i_lock. A beat is accepted when i_s_valid & o_s_ready.
  - DONE: one cycle with o_done=1, then IDLE.
  - ERR: o_err=1, o_s_ready=0. Leaves only on i_start, which clears o_err and enters LOAD.
- Packing:
  - byte_idx runs 0..8.
  - Byte k is placed in bits [KERNEL_WIDTH-1-8k -: 8], so the first byte is w0 in [71:64] and the ninth is w8 in [7:0].
  - The shift/pack register is not cleared between kernels; only complete kernels are written.
- Kernel complete (accept with byte_idx==8):
  - bank = kernel_cnt[1:0]
  - addr = kernel_cnt >> 2, zero-extended to ADDR_WIDTH
  - kernel_cnt increments; byte_idx returns to 0.
- Termination:
  - i_s_last on a beat with byte_idx==8 -> write the kernel, go to DONE.
  - i_s_last with byte_idx!=8 -> ERR; the partial kernel is discarded and nothing is written.
  - A kernel completing when kernel_cnt==MAX_KERNELS, i.e. a 65th kernel -> ERR with no write.
- i_s_data is don't-care when not accepted; no state changes without acceptance.
- i_start while busy or in DONE is ignored.
- Reset mid-load: everything returns to reset values immediately; partial bank contents are not undone.

## Timing
- Reset values: o_s_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0, o_kernel_cnt=0, state IDLE.
- o_s_ready is registered-state-derived, combinational only with i_lock. It rises the cycle after i_start is sampled.
- Write latency: the 9th byte is accepted at edge t; o_wr_en/o_wr_addr/o_wr_data are registered and valid for exactly one cycle after t. o_wr_en is 0 otherwise.
- o_done: the cycle after the final write, i.e. 2 cycles after the last-beat edge. o_busy drops the same cycle o_done drops.
- i_lock asserted mid-kernel freezes byte_idx and the pack register. A write already registered still issues.
- Maximum throughput is one byte per cycle, with no bubbles between kernels.

## Structure
- Shared package wgt_pkg:
  - DATA_W, KERNEL_WIDTH, NUM_BANKS, ADDR_WIDTH, MAX_KERNELS
  - state encoding (IDLE=0, LOAD=1, DONE=2, ERR=3)
  - the bank/address mapping constant (kernel k -> bank k%4, addr k/4), shared with weight_ctrl.
- One natural sub-module, kernel_packer: the 9-byte shift/pack register plus byte_idx, with a complete strobe. The FSM, bank/address generation and flags stay in the top.

## Test plan
- Clean 36-byte load (bytes 0x01..0x24, last on byte 36) -> 4 writes:
  - bank0 addr0 data 0x010203040506070809
  - bank1 addr0 0x0A..0x12
  - bank2 addr0, bank3 addr0
  - o_done 2 cycles after last beat; o_kernel_cnt=4.
- Full 576-byte load with random valid gaps -> 64 writes, bank k%4, addr k/4 (addr 15 max), o_done, o_err=0.
- i_s_last on byte 13 -> one write (kernel 0), ERR, o_err=1, o_s_ready=0. A later i_start clears o_err and a clean load succeeds.
- 585 bytes without last -> 64 writes then ERR at the 65th kernel, no 65th write.
- i_lock held 5 cycles mid-kernel (after byte 4) -> o_s_ready=0 throughout, the kernel is packed correctly, one write.
- rstn asserted during byte 6 of kernel 2 -> all outputs 0 asynchronously. After release, i_start plus a 9-byte load writes bank0 addr0.

Source files
------------

// File: rtl/wgt_pkg.sv
// Shared constants, FSM encoding and the kernel-to-bank mapping for the weight load path.
// weight_ctrl uses the same mapping to read the banks back.
package wgt_pkg;
    localparam int DATA_W       = 8;
    localparam int KERNEL_WIDTH = 72;
    localparam int NUM_BANKS    = 4;
    localparam int ADDR_WIDTH   = 10;
    localparam int MAX_KERNELS  = 64;
    localparam int KBYTES       = KERNEL_WIDTH / DATA_W;
    localparam int CNT_W        = 7;
    localparam int IDX_W        = 4;
    localparam int BANK_SHIFT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Kernel k lands in bank k % NUM_BANKS at address k / NUM_BANKS.
    function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [CNT_W-1:0] k);
        logic [NUM_BANKS-1:0] one;
        one = {{(NUM_BANKS-1){1'b0}}, 1'b1};
        bank_sel = one << k[BANK_SHIFT-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] bank_addr(input logic [CNT_W-1:0] k);
        bank_addr = ADDR_WIDTH'(k >> BANK_SHIFT);
    endfunction
endpackage

// File: rtl/weight_stream_loader_if.sv
// Valid/ready weight byte stream between a producer and weight_stream_loader.
interface weight_stream_loader_if;
    import wgt_pkg::*;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_stream_loader_kernel_packer.sv
// Shift register gathering 9 weight bytes into one kernel word; the first byte ends up in the MSBs.
module kernel_packer
    import wgt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    acc,
    input  logic [DATA_W-1:0]       din,
    output logic                    complete,
    output logic [KERNEL_WIDTH-1:0] kword
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KBYTES - 1);

    logic [KERNEL_WIDTH-1:0] pack_r;
    logic [IDX_W-1:0]        idx_r;

    // Byte index and shift register advance only on accepted beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_r <= '0;
            idx_r  <= 4'd0;
        end else if (clr) begin
            idx_r  <= 4'd0;
        end else if (acc) begin
            pack_r <= {pack_r[KERNEL_WIDTH-DATA_W-1:0], din};
            idx_r  <= (idx_r == LAST_IDX) ? 4'd0 : idx_r + 4'd1;
        end
    end

    // The ninth byte is still on the bus, so the full word merges it in directly.
    assign complete = acc && (idx_r == LAST_IDX);
    assign kword    = {pack_r[KERNEL_WIDTH-DATA_W-1:0], din};
endmodule

// File: rtl/weight_stream_loader.sv
// Loads a stream of weight bytes as 72-bit kernels into four weight banks, round-robin.
// A one-cycle drain after the last write lets o_done trail the final write by one cycle.
module weight_stream_loader
    import wgt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic                    i_lock,
    weight_stream_loader_if.slave   s_if,
    output logic [NUM_BANKS-1:0]    o_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [KERNEL_WIDTH-1:0] o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [CNT_W-1:0]        o_kernel_cnt
);
    state_e                  state_r, state_n;
    logic                    fin_r;
    logic [CNT_W-1:0]        kcnt_r;
    logic [NUM_BANKS-1:0]    wr_en_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [KERNEL_WIDTH-1:0] wr_data_r;
    logic                    busy_r, done_r, err_r;
    logic                    start_s, ready_s, accept_s, complete_s, full_s, wr_fire_s;
    logic [KERNEL_WIDTH-1:0] kword_s;

    assign start_s    = i_start && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    assign ready_s    = (state_r == ST_LOAD) && !fin_r && !i_lock;
    assign accept_s   = s_if.s_valid && ready_s;
    assign full_s     = (kcnt_r == CNT_W'(MAX_KERNELS));
    assign wr_fire_s  = complete_s && !full_s;
    assign s_if.s_ready = ready_s;

    kernel_packer u_packer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (start_s),
        .acc      (accept_s),
        .din      (s_if.s_data),
        .complete (complete_s),
        .kword    (kword_s)
    );

    // Next-state logic; a 65th kernel or a last beat mid-kernel is fatal to the load.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_n = ST_LOAD;
                else         state_n = ST_IDLE;
            end
            ST_LOAD: begin
                if (fin_r)                                           state_n = ST_DONE;
                else if (complete_s && full_s)                       state_n = ST_ERR;
                else if (accept_s && s_if.s_last && !complete_s)     state_n = ST_ERR;
                else                                                 state_n = ST_LOAD;
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR: begin
                if (start_s) state_n = ST_LOAD;
                else         state_n = ST_ERR;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, kernel counter and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            fin_r     <= 1'b0;
            kcnt_r    <= 7'd0;
            wr_en_r   <= '0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            fin_r   <= wr_fire_s && s_if.s_last;
            if (start_s)        kcnt_r <= 7'd0;
            else if (wr_fire_s) kcnt_r <= kcnt_r + 7'd1;
            wr_en_r <= wr_fire_s ? bank_sel(kcnt_r) : '0;
            if (wr_fire_s) begin
                wr_addr_r <= bank_addr(kcnt_r);
                wr_data_r <= kword_s;
            end
            busy_r <= (state_n == ST_LOAD) || (state_n == ST_DONE);
            done_r <= (state_n == ST_DONE);
            err_r  <= (state_n == ST_ERR);
        end
    end

    assign o_wr_en      = wr_en_r;
    assign o_wr_addr    = wr_addr_r;
    assign o_wr_data    = wr_data_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_err        = err_r;
    assign o_kernel_cnt = kcnt_r;
endmodule
